// File: rtl/ls_arbiter.sv
// Local-store port arbiter: shares one 128-bit single-ported SRAM between the
// MEM-stage load/store path, the DMA engine and instruction fetch.
module ls_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 128,
  parameter int BURST_LEN  = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic              dma_burst,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              ls_gnt,
  output logic              dma_gnt,
  output logic              if_gnt,
  output logic              ls_rvalid,
  output logic              dma_rvalid,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              ls_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int SC_W = $clog2(STARVE_MAX + 1);
  localparam int BC_W = $clog2(BURST_LEN + 1);
  localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);
  localparam logic [BC_W-1:0] LAST_BEAT  = BC_W'(BURST_LEN - 1);
  localparam logic            BURST_EN   = (BURST_LEN > 1);

  typedef enum logic [0:0] {ARB = 1'b0, BURST = 1'b1} state_t;
  typedef enum logic [1:0] {
    OWN_LS = 2'd0, OWN_DMA = 2'd1, OWN_IF = 2'd2, OWN_NONE = 2'd3
  } owner_t;

  state_t            state_r;
  owner_t            owner_r;
  logic              rd_pend_r;
  logic [SC_W-1:0]   starve_cnt_r;
  logic [BC_W-1:0]   beat_cnt_r;

  logic              force_if_s;
  logic              ls_gnt_s;
  logic              dma_gnt_s;
  logic              if_gnt_s;
  logic              mem_en_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [DATA_W-1:0] mem_wdata_s;

  // Same-cycle grant: starvation override first, then ls > dma > ifetch.
  always_comb begin
    force_if_s = if_req & (starve_cnt_r == STARVE_LIM);
    ls_gnt_s   = 1'b0;
    dma_gnt_s  = 1'b0;
    if_gnt_s   = 1'b0;
    if (force_if_s) begin
      if_gnt_s = 1'b1;
    end else if (ls_req) begin
      ls_gnt_s = 1'b1;
    end else if (dma_req) begin
      dma_gnt_s = 1'b1;
    end else if (if_req) begin
      if_gnt_s = 1'b1;
    end else begin
      if_gnt_s = 1'b0;
    end
  end

  // SRAM port mux driven by the one-hot winner.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_addr_s  = {ADDR_W{1'b0}};
    mem_wdata_s = {DATA_W{1'b0}};
    case ({ls_gnt_s, dma_gnt_s, if_gnt_s})
      3'b100: begin
        mem_we_s    = ls_we;
        mem_addr_s  = ls_addr;
        mem_wdata_s = ls_wdata;
      end
      3'b010: begin
        mem_we_s    = dma_we;
        mem_addr_s  = dma_addr;
        mem_wdata_s = dma_wdata;
      end
      3'b001: begin
        mem_we_s    = 1'b0;
        mem_addr_s  = if_addr;
      end
      default: begin
        mem_we_s    = 1'b0;
      end
    endcase
  end

  assign mem_en_s  = ls_gnt_s | dma_gnt_s | if_gnt_s;
  assign ls_gnt    = ls_gnt_s;
  assign dma_gnt   = dma_gnt_s;
  assign if_gnt    = if_gnt_s;
  assign ls_stall  = ls_req & ~ls_gnt_s;
  assign mem_en    = mem_en_s;
  assign mem_we    = mem_we_s;
  assign mem_addr  = mem_addr_s;
  assign mem_wdata = mem_wdata_s;

  // Saturating count of consecutive cycles ifetch asked and lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt_r <= {SC_W{1'b0}};
    end else if (if_req & ~if_gnt_s) begin
      if (starve_cnt_r != STARVE_LIM) begin
        starve_cnt_r <= starve_cnt_r + SC_W'(1);
      end
    end else begin
      starve_cnt_r <= {SC_W{1'b0}};
    end
  end

  // Locked-burst tracker; an ls-preempted cycle is not a counted beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ARB;
      beat_cnt_r <= {BC_W{1'b0}};
    end else begin
      case (state_r)
        ARB: begin
          if (dma_gnt_s & dma_burst & BURST_EN) begin
            state_r    <= BURST;
            beat_cnt_r <= BC_W'(1);
          end
        end
        BURST: begin
          if (!dma_req) begin
            state_r    <= ARB;
            beat_cnt_r <= {BC_W{1'b0}};
          end else if (dma_gnt_s) begin
            if (beat_cnt_r == LAST_BEAT) begin
              state_r    <= ARB;
              beat_cnt_r <= {BC_W{1'b0}};
            end else begin
              beat_cnt_r <= beat_cnt_r + BC_W'(1);
            end
          end
        end
        default: begin
          state_r    <= ARB;
          beat_cnt_r <= {BC_W{1'b0}};
        end
      endcase
    end
  end

  // Remember who owns the read in flight so the return is steered next cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_pend_r <= 1'b0;
      owner_r   <= OWN_NONE;
    end else begin
      rd_pend_r <= mem_en_s & ~mem_we_s;
      if (ls_gnt_s) begin
        owner_r <= OWN_LS;
      end else if (dma_gnt_s) begin
        owner_r <= OWN_DMA;
      end else if (if_gnt_s) begin
        owner_r <= OWN_IF;
      end else begin
        owner_r <= OWN_NONE;
      end
    end
  end

  assign ls_rvalid  = rd_pend_r & (owner_r == OWN_LS);
  assign dma_rvalid = rd_pend_r & (owner_r == OWN_DMA);
  assign if_rvalid  = rd_pend_r & (owner_r == OWN_IF);
  assign rdata      = mem_rdata;

endmodule

// File: tb/tb_ls_arbiter.sv
// Self-checking bench for ls_arbiter: per-cycle behavioural model plus
// hand-computed expectations for the directed scenarios.
module tb_ls_arbiter;

  localparam int ADDR_W     = 14;
  localparam int DATA_W     = 128;
  localparam int BURST_LEN  = 4;
  localparam int STARVE_MAX = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              ls_req, ls_we, dma_req, dma_we, dma_burst, if_req;
  logic [ADDR_W-1:0] ls_addr, dma_addr, if_addr;
  logic [DATA_W-1:0] ls_wdata, dma_wdata;
  logic              ls_gnt, dma_gnt, if_gnt;
  logic              ls_rvalid, dma_rvalid, if_rvalid;
  logic [DATA_W-1:0] rdata;
  logic              ls_stall, mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic [DATA_W-1:0] sram  [0:16383];
  bit                wr_ok [0:16383];

  int  n_cmp = 0;
  int  n_fail = 0;
  int  hand_id = 0;
  logic done = 1'b0;

  // values recorded by the stimulus for the hand checks
  int       ls_cnt = 0, dma_cnt = 0, stall_c = 0;
  int       first_if = 0, stalls = 0, starve_after = -1;
  logic [5:0] dma_pat = 6'd0, ls_pat = 6'd0;
  int       st5 = -1, rst_state = -1;
  logic     pre_rv = 1'b0;
  logic [2:0] rst_rv = 3'b111;

  // behavioural model state
  int                m_starve, m_burst, m_beats, m_rv;
  logic [DATA_W-1:0] m_rv_data;

  always #5 clk = ~clk;

  ls_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN),
               .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_burst(dma_burst),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .if_req(if_req), .if_addr(if_addr),
    .ls_gnt(ls_gnt), .dma_gnt(dma_gnt), .if_gnt(if_gnt),
    .ls_rvalid(ls_rvalid), .dma_rvalid(dma_rvalid), .if_rvalid(if_rvalid),
    .rdata(rdata), .ls_stall(ls_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
    return {8{2'b01, a}};
  endfunction

  function automatic logic [DATA_W-1:0] peek(input logic [ADDR_W-1:0] a);
    return wr_ok[a] ? sram[a] : pat(a);
  endfunction

  // SRAM stub: read data appears one cycle after a read access
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        sram[mem_addr]  <= mem_wdata;
        wr_ok[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= peek(mem_addr);
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Compare process: model evaluated and checked on every falling edge
  initial begin
    int e;
    logic e_we, e_read;
    logic [ADDR_W-1:0] e_addr;
    m_starve = 0; m_burst = 0; m_beats = 0; m_rv = 0; m_rv_data = '0;
    while (!done) begin
      @(negedge clk);
      if (!reset) begin
        m_starve = 0; m_burst = 0; m_beats = 0; m_rv = 0;
      end
      if (if_req && m_starve == STARVE_MAX) e = 3;
      else if (ls_req)  e = 1;
      else if (dma_req) e = 2;
      else if (if_req)  e = 3;
      else              e = 0;
      e_we   = (e == 1) ? ls_we : (e == 2) ? dma_we : 1'b0;
      e_addr = (e == 1) ? ls_addr : (e == 2) ? dma_addr : if_addr;
      e_read = (e != 0) && !e_we;

      chk("ls_gnt",   128'(ls_gnt),   128'(e == 1));
      chk("dma_gnt",  128'(dma_gnt),  128'(e == 2));
      chk("if_gnt",   128'(if_gnt),   128'(e == 3));
      chk("mem_en",   128'(mem_en),   128'(e != 0));
      chk("ls_stall", 128'(ls_stall), 128'(ls_req && e != 1));
      if (e != 0) begin
        chk("mem_we",   128'(mem_we),   128'(e_we));
        chk("mem_addr", 128'(mem_addr), 128'(e_addr));
        if (e_we) chk("mem_wdata", mem_wdata, (e == 1) ? ls_wdata : dma_wdata);
      end
      chk("ls_rvalid",  128'(ls_rvalid),  128'(m_rv == 1));
      chk("dma_rvalid", 128'(dma_rvalid), 128'(m_rv == 2));
      chk("if_rvalid",  128'(if_rvalid),  128'(m_rv == 3));
      if (m_rv != 0) chk("rdata", rdata, m_rv_data);
      chk("starve_cnt", 128'(int'(dut.starve_cnt_r)), 128'(m_starve));
      chk("in_burst",   128'(int'(dut.state_r)),      128'(m_burst));
      if (m_burst != 0) chk("beat_cnt", 128'(int'(dut.beat_cnt_r)), 128'(m_beats));

      case (hand_id)
        10: begin
          chk("rst_mem_en", 128'(mem_en), 128'(1'b0));
          chk("rst_rvalid", 128'({ls_rvalid, dma_rvalid, if_rvalid}), 128'(3'b000));
          chk("rst_starve", 128'(int'(dut.starve_cnt_r)), 128'(0));
          chk("rst_state",  128'(int'(dut.state_r)), 128'(0));
        end
        1: begin
          chk("t1_ls_gnt", 128'(ls_gnt), 128'(1'b1));
          chk("t1_addr",   128'(mem_addr), 128'(14'h010));
          chk("t1_we",     128'(mem_we), 128'(1'b0));
        end
        2: begin
          chk("t2_ls_rvalid", 128'(ls_rvalid), 128'(1'b1));
          chk("t2_rdata",     rdata, {8{16'h4010}});
          chk("t2_dma_gnt",   128'(dma_gnt), 128'(1'b1));
          chk("t2_addr",      128'(mem_addr), 128'(14'h3FFF));
          chk("t2_wdata",     mem_wdata, {16{8'hA5}});
          chk("t2_we",        128'(mem_we), 128'(1'b1));
        end
        3: begin
          chk("t3_if_gnt",  128'(if_gnt), 128'(1'b1));
          chk("t3_addr",    128'(mem_addr), 128'(14'h020));
          chk("t3_we",      128'(mem_we), 128'(1'b0));
          chk("t3_dma_rv",  128'(dma_rvalid), 128'(1'b0));
        end
        4: begin
          chk("t4_if_rvalid", 128'(if_rvalid), 128'(1'b1));
          chk("t4_rdata",     rdata, {8{16'h4020}});
        end
        5: begin
          chk("cont_starve", 128'(int'(dut.starve_cnt_r)), 128'(3));
          chk("cont_ls",     128'(ls_cnt), 128'(3));
          chk("cont_dma",    128'(dma_cnt), 128'(0));
          chk("cont_stall",  128'(stall_c), 128'(0));
        end
        6: begin
          chk("starve_if_cycle", 128'(first_if), 128'(9));
          chk("starve_stalls",   128'(stalls), 128'(1));
          chk("starve_cleared",  128'(starve_after), 128'(0));
        end
        7: begin
          chk("burst_dma_pat", 128'(dma_pat), 128'(6'b111011));
          chk("burst_ls_pat",  128'(ls_pat), 128'(6'b000100));
          chk("burst_arb_c5",  128'(st5), 128'(0));
        end
        8: begin
          chk("mid_pre_rv",   128'(pre_rv), 128'(1'b1));
          chk("mid_rv_drop",  128'(rst_rv), 128'(3'b000));
          chk("mid_state",    128'(rst_state), 128'(0));
        end
        9: begin
          chk("rel_beat", 128'(int'(dut.beat_cnt_r)), 128'(1));
          chk("rel_state", 128'(int'(dut.state_r)), 128'(1));
        end
        default: ;
      endcase

      if (reset) begin
        if (if_req && e != 3) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
        else m_starve = 0;
        if (m_burst == 0) begin
          if (e == 2 && dma_burst && BURST_LEN > 1) begin
            m_burst = 1; m_beats = 1;
          end
        end else if (!dma_req) begin
          m_burst = 0; m_beats = 0;
        end else if (e == 2) begin
          m_beats++;
          if (m_beats == BURST_LEN) begin
            m_burst = 0; m_beats = 0;
          end
        end
        m_rv      = e_read ? e : 0;
        m_rv_data = peek(e_addr);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = 14'h0; ls_wdata = 128'h0;
    dma_req = 1'b0; dma_we = 1'b0; dma_burst = 1'b0; dma_addr = 14'h0;
    dma_wdata = 128'h0; if_req = 1'b0; if_addr = 14'h0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    hand_id = 0;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  // Stimulus
  initial begin
    int beats;
    idle();
    @(posedge clk); #1; hand_id = 10;
    next(); reset = 1'b1;

    next(); ls_req = 1'b1; ls_addr = 14'h010; ls_wdata = {4{32'hDEADBEEF}}; hand_id = 1;
    next(); idle(); dma_req = 1'b1; dma_we = 1'b1; dma_addr = 14'h3FFF;
    dma_wdata = {16{8'hA5}}; hand_id = 2;
    next(); idle(); if_req = 1'b1; if_addr = 14'h020; hand_id = 3;
    next(); idle(); hand_id = 4;
    next(); dma_req = 1'b1; dma_addr = 14'h3FFF;
    next(); idle();

    for (int k = 0; k < 3; k++) begin
      next();
      ls_req = 1'b1; ls_addr = 14'h100 + 14'(k);
      dma_req = 1'b1; dma_addr = 14'h200; if_req = 1'b1; if_addr = 14'h300;
      sample();
      ls_cnt  += int'(ls_gnt);
      dma_cnt += int'(dma_gnt);
      stall_c += int'(ls_stall);
    end
    next(); idle(); hand_id = 5;
    next(); idle();

    for (int k = 1; k <= 10; k++) begin
      next();
      ls_req = 1'b1; ls_addr = 14'h040; if_req = 1'b1; if_addr = 14'h080;
      sample();
      if (if_gnt && first_if == 0) first_if = k;
      stalls += int'(ls_stall);
      if (k == 10) starve_after = int'(dut.starve_cnt_r);
    end
    next(); idle(); hand_id = 6;
    next(); idle();

    beats = 0;
    for (int k = 0; k < 6; k++) begin
      next();
      dma_req = 1'b1; dma_burst = 1'b1; dma_we = 1'b1;
      dma_addr = 14'h500 + 14'(beats); dma_wdata = {16{8'(beats + 1)}};
      ls_req = (k == 2); ls_addr = 14'h600;
      sample();
      dma_pat[k] = dma_gnt;
      ls_pat[k]  = ls_gnt;
      beats += int'(dma_gnt);
      if (k == 5) st5 = int'(dut.state_r);
    end
    next(); idle(); hand_id = 7;
    next(); idle();

    next(); dma_req = 1'b1; dma_burst = 1'b1; dma_we = 1'b0; dma_addr = 14'h3FFF;
    next();
    pre_rv = dma_rvalid;
    #1; reset = 1'b0; #1;
    rst_rv    = {ls_rvalid, dma_rvalid, if_rvalid};
    rst_state = int'(dut.state_r);
    hand_id   = 8;
    next(); reset = 1'b1;
    next(); hand_id = 9;
    next(); idle();
    next(); idle();
    done = 1'b1;
  end

endmodule
